// File: rtl/fetch_exception_sequencer.sv
// Front-end control sequencer: reset, instruction fetch with memory wait states, decode/legality,
// multi-cycle mult/div stalls and the exception path. All other instructions go to the execute FSM.
module fetch_exception_sequencer #(
    parameter int unsigned MEM_WAIT       = 1,
    parameter int unsigned MULTDIV_CYCLES = 32,
    parameter int unsigned SP_INIT        = 227,
    parameter int unsigned VEC_OPCODE     = 253,
    parameter int unsigned VEC_OVF        = 254,
    parameter int unsigned VEC_DIV0       = 255
) (
    input  logic        clock,
    input  logic        RESET_in,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        overflow,
    input  logic        div_zero,
    input  logic        exec_done,
    output logic        RESET_out,
    output logic        sp_write,
    output logic [31:0] sp_init,
    output logic        MemRead,
    output logic        IorD,
    output logic        IRwrite,
    output logic        PCwrite,
    output logic [1:0]  pc_src,
    output logic        EPCwrite,
    output logic [31:0] exc_addr,
    output logic [1:0]  exc_cause,
    output logic        MultOp,
    output logic        DivOp,
    output logic        exec_start,
    output logic        halted
);

    localparam int unsigned CNT_MAX = (MEM_WAIT > MULTDIV_CYCLES) ? MEM_WAIT : MULTDIV_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] MEM_LAST = CW'(MEM_WAIT);
    localparam logic [CW-1:0] MD_LAST  = CW'(MULTDIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_RESET_SP = 4'd1;
    localparam logic [3:0] S_FETCH    = 4'd2;
    localparam logic [3:0] S_IR_WRITE = 4'd3;
    localparam logic [3:0] S_DECODE   = 4'd4;
    localparam logic [3:0] S_MULDIV   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_EXC_SAVE = 4'd7;
    localparam logic [3:0] S_EXC_READ = 4'd8;
    localparam logic [3:0] S_EXC_LOAD = 4'd9;
    localparam logic [3:0] S_BREAK    = 4'd10;

    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;

    localparam logic [5:0] FN_BREAK = 6'h0d;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1a;

    logic [3:0]    state;
    logic [3:0]    state_next;
    logic [CW-1:0] cnt;
    logic [1:0]    cause_next;
    logic          is_div;
    logic          is_div_next;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
            6'h0a, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic fn_legal(input logic [5:0] fn);
        case (fn)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h0d,
            6'h10, 6'h12, 6'h13, 6'h18, 6'h1a, 6'h20, 6'h22, 6'h24, 6'h2a: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // State register; the counter restarts on every state change and saturates otherwise.
    always_ff @(posedge clock) begin
        if (RESET_in) begin
            state     <= S_RESET;
            cnt       <= '0;
            exc_cause <= CAUSE_OPCODE;
            is_div    <= 1'b0;
        end else begin
            state     <= state_next;
            exc_cause <= cause_next;
            is_div    <= is_div_next;
            if (state_next != state)
                cnt <= '0;
            else if (cnt != CNT_SAT)
                cnt <= cnt + CW'(1);
        end
    end

    // Next-state logic, including the latched exception cause and mult/div selection.
    always_comb begin
        state_next  = state;
        cause_next  = exc_cause;
        is_div_next = is_div;
        case (state)
            S_RESET:    state_next = S_RESET_SP;
            S_RESET_SP: state_next = S_FETCH;
            S_FETCH:    if (cnt == MEM_LAST) state_next = S_IR_WRITE;
            S_IR_WRITE: state_next = S_DECODE;
            S_DECODE: begin
                if (!op_legal(opcode) || (opcode == 6'h00 && !fn_legal(funct))) begin
                    state_next = S_EXC_SAVE;
                    cause_next = CAUSE_OPCODE;
                end else if (opcode == 6'h00 && funct == FN_BREAK) begin
                    state_next = S_BREAK;
                end else if (opcode == 6'h00 && (funct == FN_MULT || funct == FN_DIV)) begin
                    state_next  = S_MULDIV;
                    is_div_next = (funct == FN_DIV);
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_MULDIV: begin
                if (cnt == '0 && is_div && div_zero) begin
                    state_next = S_EXC_SAVE;
                    cause_next = CAUSE_DIV0;
                end else if (cnt == MD_LAST) begin
                    state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (overflow) begin
                        state_next = S_EXC_SAVE;
                        cause_next = CAUSE_OVF;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_EXC_SAVE: state_next = S_EXC_READ;
            S_EXC_READ: if (cnt == MEM_LAST) state_next = S_EXC_LOAD;
            S_EXC_LOAD: state_next = S_FETCH;
            S_BREAK:    state_next = S_BREAK;
            default:    state_next = S_RESET;
        endcase
    end

    // Moore output decode from state and counter.
    always_comb begin
        RESET_out  = 1'b0;
        sp_write   = 1'b0;
        MemRead    = 1'b0;
        IorD       = 1'b0;
        IRwrite    = 1'b0;
        PCwrite    = 1'b0;
        pc_src     = 2'd0;
        EPCwrite   = 1'b0;
        MultOp     = 1'b0;
        DivOp      = 1'b0;
        exec_start = 1'b0;
        halted     = 1'b0;
        case (state)
            S_RESET:    RESET_out = 1'b1;
            S_RESET_SP: sp_write  = 1'b1;
            S_FETCH: begin
                MemRead = 1'b1;
                PCwrite = (cnt == MEM_LAST);
            end
            S_IR_WRITE: IRwrite = 1'b1;
            S_MULDIV: begin
                MultOp = (cnt == '0) && !is_div;
                DivOp  = (cnt == '0) && is_div;
            end
            S_EXEC:     exec_start = (cnt == '0);
            S_EXC_SAVE: EPCwrite   = 1'b1;
            S_EXC_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_EXC_LOAD: begin
                PCwrite = 1'b1;
                pc_src  = 2'd1;
            end
            S_BREAK:    halted = 1'b1;
            default:    ;
        endcase
    end

    always_comb begin
        case (exc_cause)
            CAUSE_OPCODE: exc_addr = 32'(VEC_OPCODE);
            CAUSE_OVF:    exc_addr = 32'(VEC_OVF);
            default:      exc_addr = 32'(VEC_DIV0);
        endcase
    end

    assign sp_init = 32'(SP_INIT);

endmodule

// File: tb/tb_fetch_exception_sequencer.sv
// Directed bench for fetch_exception_sequencer: one task per scenario, outputs sampled on the falling edge.
module tb_fetch_exception_sequencer;

    // Output vector bit order: RESET_out sp_write MemRead IorD IRwrite PCwrite pc_src[1:0]
    // EPCwrite MultOp DivOp exec_start halted
    localparam logic [12:0] O_RST  = 13'h1000;
    localparam logic [12:0] O_SP   = 13'h0800;
    localparam logic [12:0] O_FW   = 13'h0400;
    localparam logic [12:0] O_FL   = 13'h0480;
    localparam logic [12:0] O_IR   = 13'h0100;
    localparam logic [12:0] O_IDLE = 13'h0000;
    localparam logic [12:0] O_EPC  = 13'h0010;
    localparam logic [12:0] O_XR   = 13'h0600;
    localparam logic [12:0] O_XL   = 13'h00a0;
    localparam logic [12:0] O_MUL  = 13'h0008;
    localparam logic [12:0] O_DIV  = 13'h0004;
    localparam logic [12:0] O_EXS  = 13'h0002;
    localparam logic [12:0] O_HLT  = 13'h0001;

    logic        clock = 1'b0;
    logic        RESET_in, overflow, div_zero, exec_done;
    logic [5:0]  opcode, funct;
    logic        RESET_out, sp_write, MemRead, IorD, IRwrite, PCwrite, EPCwrite;
    logic        MultOp, DivOp, exec_start, halted;
    logic [1:0]  pc_src, exc_cause;
    logic [31:0] sp_init, exc_addr;
    logic [12:0] ob;

    logic        r3, z3;
    logic [5:0]  op3, fn3;
    logic        RESET_out3, sp_write3, MemRead3, IorD3, IRwrite3, PCwrite3, EPCwrite3;
    logic        MultOp3, DivOp3, exec_start3, halted3;
    logic [1:0]  pc_src3, exc_cause3;
    logic [31:0] sp_init3, exc_addr3;
    logic [12:0] ob3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    fetch_exception_sequencer #(.MEM_WAIT(1), .MULTDIV_CYCLES(32)) u_dut (
        .clock(clock), .RESET_in(RESET_in), .opcode(opcode), .funct(funct),
        .overflow(overflow), .div_zero(div_zero), .exec_done(exec_done),
        .RESET_out(RESET_out), .sp_write(sp_write), .sp_init(sp_init),
        .MemRead(MemRead), .IorD(IorD), .IRwrite(IRwrite), .PCwrite(PCwrite),
        .pc_src(pc_src), .EPCwrite(EPCwrite), .exc_addr(exc_addr), .exc_cause(exc_cause),
        .MultOp(MultOp), .DivOp(DivOp), .exec_start(exec_start), .halted(halted)
    );

    fetch_exception_sequencer #(.MEM_WAIT(3), .MULTDIV_CYCLES(32)) u_w3 (
        .clock(clock), .RESET_in(r3), .opcode(op3), .funct(fn3),
        .overflow(z3), .div_zero(z3), .exec_done(z3),
        .RESET_out(RESET_out3), .sp_write(sp_write3), .sp_init(sp_init3),
        .MemRead(MemRead3), .IorD(IorD3), .IRwrite(IRwrite3), .PCwrite(PCwrite3),
        .pc_src(pc_src3), .EPCwrite(EPCwrite3), .exc_addr(exc_addr3), .exc_cause(exc_cause3),
        .MultOp(MultOp3), .DivOp(DivOp3), .exec_start(exec_start3), .halted(halted3)
    );

    assign ob  = {RESET_out, sp_write, MemRead, IorD, IRwrite, PCwrite, pc_src,
                  EPCwrite, MultOp, DivOp, exec_start, halted};
    assign ob3 = {RESET_out3, sp_write3, MemRead3, IorD3, IRwrite3, PCwrite3, pc_src3,
                  EPCwrite3, MultOp3, DivOp3, exec_start3, halted3};

    task automatic tick();
        @(negedge clock);
    endtask

    // From an observed FETCH first cycle, advance to the observed DECODE cycle (MEM_WAIT=1).
    task automatic to_decode();
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        RESET_in = 1'b1;
        tick();
        RESET_in = 1'b0;
        n_checks++; if (ob !== O_RST) $display("FAIL reset_state: got %h want %h", ob, O_RST); else n_pass++;
        tick();
        n_checks++; if (ob !== O_SP) $display("FAIL reset_sp: got %h want %h", ob, O_SP); else n_pass++;
        n_checks++; if (sp_init !== 32'd227) $display("FAIL sp_init: got %0d want 227", sp_init); else n_pass++;
        tick();
        n_checks++; if (ob !== O_FW) $display("FAIL fetch_wait: got %h want %h", ob, O_FW); else n_pass++;
        tick();
        n_checks++; if (ob !== O_FL) $display("FAIL fetch_last: got %h want %h", ob, O_FL); else n_pass++;
        tick();
        n_checks++; if (ob !== O_IR) $display("FAIL ir_write: got %h want %h", ob, O_IR); else n_pass++;
        tick();
        n_checks++; if (ob !== O_IDLE) $display("FAIL decode_idle: got %h want %h", ob, O_IDLE); else n_pass++;
    endtask

    task automatic test_add();
        int epc_seen;
        epc_seen = 0;
        opcode = 6'h00; funct = 6'h20;
        tick();
        n_checks++; if (ob !== O_EXS) $display("FAIL add_start: got %h want %h", ob, O_EXS); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ob !== O_IDLE) epc_seen++;
        end
        n_checks++; if (epc_seen != 0) $display("FAIL add_wait: got %0d busy cycles want 0", epc_seen); else n_pass++;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        n_checks++; if (ob !== O_FW) $display("FAIL add_to_fetch: got %h want %h", ob, O_FW); else n_pass++;
        to_decode();
    endtask

    task automatic test_overflow();
        opcode = 6'h08; funct = 6'h00;
        tick();
        n_checks++; if (ob !== O_EXS) $display("FAIL ovf_start: got %h want %h", ob, O_EXS); else n_pass++;
        exec_done = 1'b1; overflow = 1'b1;
        tick();
        exec_done = 1'b0; overflow = 1'b0;
        n_checks++; if (ob !== O_EPC) $display("FAIL ovf_epc: got %h want %h", ob, O_EPC); else n_pass++;
        tick();
        n_checks++; if (ob !== O_XR) $display("FAIL ovf_read0: got %h want %h", ob, O_XR); else n_pass++;
        n_checks++; if (exc_addr !== 32'd254) $display("FAIL ovf_addr: got %0d want 254", exc_addr); else n_pass++;
        tick();
        n_checks++; if (ob !== O_XR) $display("FAIL ovf_read1: got %h want %h", ob, O_XR); else n_pass++;
        tick();
        n_checks++; if (ob !== O_XL) $display("FAIL ovf_load: got %h want %h", ob, O_XL); else n_pass++;
        n_checks++; if (exc_cause !== 2'd1) $display("FAIL ovf_cause: got %0d want 1", exc_cause); else n_pass++;
        tick();
        n_checks++; if (ob !== O_FW) $display("FAIL ovf_refetch: got %h want %h", ob, O_FW); else n_pass++;
        to_decode();
    endtask

    task automatic test_illegal();
        opcode = 6'h3f; funct = 6'h00;
        tick();
        n_checks++; if (ob !== O_EPC) $display("FAIL ill_epc: got %h want %h", ob, O_EPC); else n_pass++;
        n_checks++; if (exc_addr !== 32'd253) $display("FAIL ill_addr: got %0d want 253", exc_addr); else n_pass++;
        n_checks++; if (exc_cause !== 2'd0) $display("FAIL ill_cause: got %0d want 0", exc_cause); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (ob !== O_XL) $display("FAIL ill_load: got %h want %h", ob, O_XL); else n_pass++;
        tick();
        to_decode();
        // R-format with an undefined funct is also illegal
        opcode = 6'h00; funct = 6'h3f;
        tick();
        n_checks++; if (ob !== O_EPC) $display("FAIL ill_funct: got %h want %h", ob, O_EPC); else n_pass++;
        tick(); tick(); tick(); tick();
        to_decode();
    endtask

    task automatic test_div0();
        opcode = 6'h00; funct = 6'h1a; div_zero = 1'b1;
        tick();
        n_checks++; if (ob !== O_DIV) $display("FAIL div0_pulse: got %h want %h", ob, O_DIV); else n_pass++;
        tick();
        div_zero = 1'b0;
        n_checks++; if (ob !== O_EPC) $display("FAIL div0_epc: got %h want %h", ob, O_EPC); else n_pass++;
        n_checks++; if (exc_addr !== 32'd255) $display("FAIL div0_addr: got %0d want 255", exc_addr); else n_pass++;
        n_checks++; if (exc_cause !== 2'd2) $display("FAIL div0_cause: got %0d want 2", exc_cause); else n_pass++;
        tick(); tick(); tick(); tick();
        to_decode();
    endtask

    task automatic test_div();
        int n;
        opcode = 6'h00; funct = 6'h1a; div_zero = 1'b0;
        tick();
        n_checks++; if (ob !== O_DIV) $display("FAIL div_pulse: got %h want %h", ob, O_DIV); else n_pass++;
        n = 1;
        tick();
        while (ob === O_IDLE && n < 40) begin
            n++;
            tick();
        end
        n_checks++; if (n != 32) $display("FAIL div_cycles: got %0d want 32", n); else n_pass++;
        n_checks++; if (ob !== O_FW) $display("FAIL div_to_fetch: got %h want %h", ob, O_FW); else n_pass++;
        to_decode();
    endtask

    task automatic test_mult();
        int n;
        opcode = 6'h00; funct = 6'h18;
        tick();
        n_checks++; if (ob !== O_MUL) $display("FAIL mult_pulse: got %h want %h", ob, O_MUL); else n_pass++;
        tick();
        n_checks++; if (ob !== O_IDLE) $display("FAIL mult_once: got %h want %h", ob, O_IDLE); else n_pass++;
        n = 2;
        tick();
        while (ob === O_IDLE && n < 40) begin
            n++;
            tick();
        end
        n_checks++; if (n != 32 || ob !== O_FW) $display("FAIL mult_end: got %0d cycles %h want 32 %h", n, ob, O_FW); else n_pass++;
        to_decode();
    endtask

    task automatic test_reset_midfetch();
        opcode = 6'h00; funct = 6'h20;
        tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        tick();
        n_checks++; if (ob !== O_FL) $display("FAIL mid_fetch2: got %h want %h", ob, O_FL); else n_pass++;
        RESET_in = 1'b1;
        tick();
        RESET_in = 1'b0;
        n_checks++; if (ob !== O_RST) $display("FAIL mid_reset: got %h want %h", ob, O_RST); else n_pass++;
        tick();
        tick();
        n_checks++; if (ob !== O_FW) $display("FAIL mid_cnt0: got %h want %h", ob, O_FW); else n_pass++;
        tick();
        n_checks++; if (ob !== O_FL) $display("FAIL mid_cnt1: got %h want %h", ob, O_FL); else n_pass++;
        tick(); tick();
    endtask

    task automatic test_break();
        int bad;
        bad = 0;
        opcode = 6'h00; funct = 6'h0d;
        tick();
        n_checks++; if (ob !== O_HLT) $display("FAIL brk_enter: got %h want %h", ob, O_HLT); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ob !== O_HLT) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL brk_hold: got %0d non-halted cycles want 0", bad); else n_pass++;
        RESET_in = 1'b1;
        tick();
        RESET_in = 1'b0;
        n_checks++; if (ob !== O_RST) $display("FAIL brk_reset: got %h want %h", ob, O_RST); else n_pass++;
        tick();
        n_checks++; if (ob !== O_SP) $display("FAIL brk_sp: got %h want %h", ob, O_SP); else n_pass++;
    endtask

    task automatic test_mem_wait3();
        int n;
        int bad;
        bad = 0;
        r3 = 1'b0;
        n_checks++; if (ob3 !== O_RST) $display("FAIL w3_reset: got %h want %h", ob3, O_RST); else n_pass++;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ob3 !== O_FW) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL w3_fetch_wait: got %0d bad cycles want 0", bad); else n_pass++;
        tick();
        n_checks++; if (ob3 !== O_FL) $display("FAIL w3_fetch_last: got %h want %h", ob3, O_FL); else n_pass++;
        tick();
        tick();
        op3 = 6'h3f;
        tick();
        n_checks++; if (ob3 !== O_EPC) $display("FAIL w3_epc: got %h want %h", ob3, O_EPC); else n_pass++;
        n = 0;
        tick();
        while (ob3 === O_XR && n < 10) begin
            n++;
            tick();
        end
        n_checks++; if (n != 4) $display("FAIL w3_read_len: got %0d want 4", n); else n_pass++;
        n_checks++; if (ob3 !== O_XL) $display("FAIL w3_load: got %h want %h", ob3, O_XL); else n_pass++;
        n_checks++; if (exc_addr3 !== 32'd253 || exc_cause3 !== 2'd0)
            $display("FAIL w3_vec: got %0d/%0d want 253/0", exc_addr3, exc_cause3); else n_pass++;
        n_checks++; if (sp_init3 !== 32'd227) $display("FAIL w3_sp_init: got %0d want 227", sp_init3); else n_pass++;
    endtask

    initial begin
        RESET_in = 1'b1; opcode = 6'h00; funct = 6'h00;
        overflow = 1'b0; div_zero = 1'b0; exec_done = 1'b0;
        r3 = 1'b1; z3 = 1'b0; op3 = 6'h00; fn3 = 6'h00;
        test_reset();
        test_add();
        test_overflow();
        test_illegal();
        test_div0();
        test_div();
        test_mult();
        test_reset_midfetch();
        test_break();
        test_mem_wait3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_exception_sequencer.md
Name: fetch_exception_sequencer

Overview:
Parametrised successor to the multicycle control FSM. It owns the processor front end (reset sequence, instruction fetch with configurable memory wait states, decode/legality check), multi-cycle mult/div stalls and the exception path (EPC save, vector read, PC load).
A downstream execute FSM handles all other instructions through an exec_start/exec_done handshake.

Parameters:
MEM_WAIT, 1, extra cycles memory needs after MemRead before data is valid (0..15).
MULTDIV_CYCLES, 32, cycles the mult/div datapath needs; minimum 1.
SP_INIT, 227, value driven on sp_init for the reset SP write.
VEC_OPCODE, 253, byte address of the illegal-opcode handler byte.
VEC_OVF, 254, byte address of the overflow handler byte.
VEC_DIV0, 255, byte address of the divide-by-zero handler byte.

Ports:
clock  in  1  system clock; single clock domain, all state changes on rising edge.
RESET_in  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
opcode  in  6  IR[31:26].
funct  in  6  IR[5:0].
overflow  in  1  ALU overflow from the execute path.
div_zero  in  1  divisor==0 flag from the divider.
exec_done  in  1  execute FSM finished the current instruction.
RESET_out  out  1  datapath register reset.
sp_write  out  1  write sp_init into register 29.
sp_init  out  32  constant SP_INIT.
MemRead  out  1  memory read.
IorD  out  1  memory address select: 0 = PC, 1 = exc_addr.
IRwrite  out  1  load IR.
PCwrite  out  1  load PC.
pc_src  out  2  PC source: 0 = ALU (PC+4), 1 = zero-extended memory byte.
EPCwrite  out  1  load EPC with ALU result (PC-4).
exc_addr  out  32  zero-extended vector address for the latched cause.
exc_cause  out  2  0 = opcode, 1 = overflow, 2 = div0.
MultOp  out  1  start-mult pulse.
DivOp  out  1  start-div pulse.
exec_start  out  1  start pulse to the execute FSM.
halted  out  1  high in BREAK.

Behaviour:
- Moore outputs: every output is decoded from state plus counter only. Outputs not listed for a state are 0.
- Reset:
  - RESET_in high at an edge forces state RESET, clears counter and exc_cause, and overrides every other transition, including BREAK and mid-wait states.
  - In RESET: RESET_out=1, everything else 0.
  - Sequence: RESET -> RESET_SP (sp_write=1, 1 cycle) -> FETCH.
- FETCH:
  - MemRead=1, IorD=0 for MEM_WAIT+1 cycles; counter runs 0..MEM_WAIT.
  - On the last cycle also PCwrite=1 and pc_src=0.
  - Then IR_WRITE: IRwrite=1, 1 cycle. Then DECODE: 1 cycle.
  - FETCH entry to DECODE = MEM_WAIT+3 cycles.
- DECODE priority:
  - Undefined opcode, or R-format with undefined funct -> EXC_SAVE, exc_cause=0.
  - Legal opcodes: 0,2,3,4,5,6,7,8,9,a,f,20,21,23,28,29,2b hex.
  - Legal R functs: 0,2,3,4,5,6,7,8,d,10,12,13,18,1a,20,22,24,2a hex.
  - funct 0x0d (break) -> BREAK. BREAK is sticky until reset; halted=1.
  - funct 0x18 or 0x1a -> MULDIV.
  - Otherwise -> EXEC.
- MULDIV:
  - Counter 0..MULTDIV_CYCLES-1. MultOp or DivOp = 1 only while counter==0.
  - div_zero sampled only at counter==0 for div: if 1 -> EXC_SAVE with exc_cause=2, and no further cycles are spent.
  - Otherwise, after the last count -> FETCH.
- EXEC:
  - exec_start=1 on the first cycle only. The FSM waits, unbounded, for exec_done, which is honoured from the first cycle on.
  - exec_done & overflow -> EXC_SAVE, exc_cause=1.
  - exec_done & !overflow -> FETCH.
  - overflow without exec_done is ignored.
- Exception path:
  - EXC_SAVE: EPCwrite=1, 1 cycle.
  - EXC_READ: MemRead=1, IorD=1 for MEM_WAIT+1 cycles.
  - EXC_LOAD: PCwrite=1, pc_src=1, 1 cycle -> FETCH.
  - exc_addr selects VEC_* by exc_cause at all times.
  - exc_cause holds its value until the next exception or reset.
- Counter: width = clog2(max(MEM_WAIT, MULTDIV_CYCLES)+1). Cleared on every state change; never wraps within a state.
- Undefined state encoding -> RESET on the next edge.

Test Plan:
- Reset, MEM_WAIT=1: RESET_in=1 for 1 edge. Next cycles: RESET_out=1, then sp_write=1 with sp_init=227, then MemRead=1 for 2 cycles with PCwrite=1 on the 2nd, IRwrite on the 3rd, DECODE on the 4th.
- add (op 0, funct 0x20): exec_start pulses for 1 cycle. exec_done asserted 3 cycles later with overflow=0 -> FETCH next cycle, EPCwrite never asserted.
- Overflow: addi with exec_done=1 and overflow=1 in the same cycle -> EPCwrite=1, then IorD=1 with exc_addr=254 for MEM_WAIT+1 cycles, then PCwrite=1 with pc_src=1, exc_cause=1.
- Illegal opcode 0x3f -> exc_addr=253, exc_cause=0. Repeat with MEM_WAIT=3: EXC_READ lasts 4 cycles.
- div, div_zero=1 -> DivOp for 1 cycle, then exc_addr=255. div with div_zero=0 and MULTDIV_CYCLES=32 -> exactly 32 MULDIV cycles, then FETCH. mult -> MultOp pulse only.
- break -> halted=1 and holds for 100 cycles. RESET_in=1 during BREAK, or during the 2nd FETCH wait cycle -> RESET_out=1 on the next cycle and the counter restarts from 0.
